// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM encoding, length-field encoding and control-strobe decode.
package prog_loader_pkg;

    localparam int PL_DEPTH  = 16;
    localparam int PL_ADDR_W = 4;
    localparam int BUS_W     = 8;

    // A length byte of zero requests a full-RAM load.
    localparam logic [BUS_W-1:0] LEN_FULL_CODE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_BYTE,
        WR_ADDR,
        WR_DATA,
        FIN
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic cpu_hold;
        logic bus_oe;
        logic mi_bar;
        logic ri;
        logic done;
    } ctl_t;

    // Control strobes are a pure function of the state being entered, so
    // mi_bar=0 and ri=1 can never coincide and an idle bus never strobes.
    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c.in_ready = (s == GET_LEN) || (s == GET_BYTE);
        c.cpu_hold = (s != IDLE);
        c.bus_oe   = (s == WR_ADDR) || (s == WR_DATA);
        c.mi_bar   = (s != WR_ADDR);
        c.ri       = (s == WR_DATA);
        c.done     = (s == FIN);
        return c;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time sequencer: fills the CPU program RAM from a byte stream
// through the MAR-load / RAM-write strobes while the CPU is held.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH  = PL_DEPTH,
    parameter int ADDR_W = PL_ADDR_W
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             load_req,
    input  logic             in_valid,
    input  logic [BUS_W-1:0] in_data,
    output logic             in_ready,
    output logic             cpu_hold,
    output logic             bus_oe,
    output logic [BUS_W-1:0] bus_data,
    output logic             mi_bar,
    output logic             ri,
    output logic             done,
    output logic             err,
    output logic [BUS_W-1:0] chk
);

    localparam int               REM_W      = ADDR_W + 1;
    localparam logic [BUS_W-1:0] DEPTH_BYTE = BUS_W'(DEPTH);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [BUS_W-1:0]   hold_q, hold_d;
    logic [BUS_W-1:0]   chk_q, chk_d;
    logic               err_q, err_d;
    ctl_t               ctl_q, ctl_d;
    logic [BUS_W-1:0]   bus_data_q, bus_data_d;
    logic               accept;

    assign accept = in_valid && ctl_q.in_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        chk_d       = chk_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = GET_LEN;
                    err_d   = 1'b0;
                    chk_d   = '0;
                    addr_d  = '0;
                end
            end
            GET_LEN: begin
                if (accept) begin
                    if (in_data == LEN_FULL_CODE) begin
                        remaining_d = REM_W'(DEPTH);
                        state_d     = GET_BYTE;
                    end else if (in_data <= DEPTH_BYTE) begin
                        remaining_d = REM_W'(in_data);
                        state_d     = GET_BYTE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            GET_BYTE: begin
                if (accept) begin
                    hold_d  = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR: state_d = WR_DATA;
            WR_DATA: begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - REM_W'(1);
                state_d     = (remaining_q == REM_W'(1)) ? FIN : GET_BYTE;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed for the state being entered and then registered.
        ctl_d = decode_ctl(state_d);
        case (state_d)
            WR_ADDR: bus_data_d = {{(BUS_W - ADDR_W){1'b0}}, addr_d};
            WR_DATA: bus_data_d = hold_d;
            default: bus_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_bar) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            chk_q       <= '0;
            err_q       <= 1'b0;
            ctl_q       <= decode_ctl(IDLE);
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            chk_q       <= chk_d;
            err_q       <= err_d;
            ctl_q       <= ctl_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign in_ready = ctl_q.in_ready;
    assign cpu_hold = ctl_q.cpu_hold;
    assign bus_oe   = ctl_q.bus_oe;
    assign mi_bar   = ctl_q.mi_bar;
    assign ri       = ctl_q.ri;
    assign done     = ctl_q.done;
    assign bus_data = bus_data_q;
    assign err      = err_q;
    assign chk      = chk_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-cycle vector table plus
// streamed loads with gaps, reset abort and boundary lengths.
module tb_prog_loader;

    logic       clk;
    logic       clr_bar;
    logic       load_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cpu_hold;
    logic       bus_oe;
    logic [7:0] bus_data;
    logic       mi_bar;
    logic       ri;
    logic       done;
    logic       err;
    logic [7:0] chk;

    int n_cmp = 0;
    int n_bad = 0;

    prog_loader dut (
        .clk      (clk),
        .clr_bar  (clr_bar),
        .load_req (load_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cpu_hold (cpu_hold),
        .bus_oe   (bus_oe),
        .bus_data (bus_data),
        .mi_bar   (mi_bar),
        .ri       (ri),
        .done     (done),
        .err      (err),
        .chk      (chk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr_bar;
        logic       load_req;
        logic       in_valid;
        logic [7:0] in_data;
        logic       ir;
        logic       hold;
        logic       oe;
        logic [7:0] bd;
        logic       mi;
        logic       ri;
        logic       done;
        logic       err;
        logic [7:0] chk;
    } vec_t;

    function automatic vec_t mkv(input logic c, input logic lr, input logic v, input logic [7:0] d,
                                 input logic ir, input logic h, input logic oe, input logic [7:0] bd,
                                 input logic mi, input logic r, input logic dn, input logic e,
                                 input logic [7:0] ck);
        vec_t t;
        t.clr_bar = c;  t.load_req = lr; t.in_valid = v; t.in_data = d;
        t.ir = ir; t.hold = h; t.oe = oe; t.bd = bd; t.mi = mi; t.ri = r;
        t.done = dn; t.err = e; t.chk = ck;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulses load_req, streams s (length byte first) and checks every write strobe.
    // abort_at > 0 returns while the bus is in the write-data cycle of that byte.
    task automatic do_load(input string tag, input logic [7:0] s[$], input bit gaps,
                           input int abort_at);
        int idx, writes, dones, exp_len;
        logic [7:0] x;
        exp_len = (s[0] == 8'h00) ? 16 : int'(s[0]);
        idx = 0; writes = 0; dones = 0; x = 8'h00;
        load_req = 1'b1;
        in_valid = 1'b0;
        tick();
        load_req = 1'b0;
        check({tag, "_hold_start"}, cpu_hold, 1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            in_valid = (idx < s.size()) && (!gaps || ($urandom_range(0, 2) != 0));
            in_data  = (idx < s.size()) ? s[idx] : 8'hEE;
            if (in_valid && in_ready) idx++;
            tick();
            check({tag, "_no_ready_on_bus"}, bus_oe & in_ready, 0);
            check({tag, "_no_mi_with_ri"}, (!mi_bar) & ri, 0);
            if (!mi_bar) check($sformatf("%s_addr%0d", tag, writes), bus_data, writes);
            if (ri) begin
                if (writes + 1 < s.size()) begin
                    check($sformatf("%s_data%0d", tag, writes), bus_data, s[writes + 1]);
                    x ^= s[writes + 1];
                end
                writes++;
                if (writes == abort_at) begin
                    in_valid = 1'b0;
                    return;
                end
            end
            if (done) dones++;
            if (!cpu_hold) break;
        end
        in_valid = 1'b0;
        check({tag, "_hold_released"}, cpu_hold, 0);
        check({tag, "_writes"}, writes, exp_len);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_chk"}, chk, x);
        check({tag, "_err"}, err, 0);
    endtask

    vec_t vecs[24];
    logic [7:0] stream[$];

    initial begin
        clr_bar = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        //                 c  lr v  data   ir h  oe bd     mi ri dn e  chk
        vecs[0]  = mkv(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[1]  = mkv(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[2]  = mkv(1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[3]  = mkv(1, 0, 1, 8'h03, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[4]  = mkv(1, 0, 1, 8'hA1, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'hA1);
        vecs[5]  = mkv(1, 0, 1, 8'h5C, 0, 1, 1, 8'hA1, 1, 1, 0, 0, 8'hA1);
        vecs[6]  = mkv(1, 0, 1, 8'h5C, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'hA1);
        vecs[7]  = mkv(1, 0, 1, 8'h5C, 0, 1, 1, 8'h01, 0, 0, 0, 0, 8'hFD);
        vecs[8]  = mkv(1, 0, 1, 8'hFF, 0, 1, 1, 8'h5C, 1, 1, 0, 0, 8'hFD);
        vecs[9]  = mkv(1, 0, 1, 8'hFF, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'hFD);
        vecs[10] = mkv(1, 0, 1, 8'hFF, 0, 1, 1, 8'h02, 0, 0, 0, 0, 8'h02);
        vecs[11] = mkv(1, 0, 0, 8'h00, 0, 1, 1, 8'hFF, 1, 1, 0, 0, 8'h02);
        vecs[12] = mkv(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 1, 0, 8'h02);
        vecs[13] = mkv(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h02);
        vecs[14] = mkv(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h02);
        vecs[15] = mkv(1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[16] = mkv(1, 0, 1, 8'h11, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h00);
        vecs[17] = mkv(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h00);
        vecs[18] = mkv(1, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[19] = mkv(1, 0, 1, 8'h01, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00);
        vecs[20] = mkv(1, 1, 1, 8'h7E, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'h7E);
        vecs[21] = mkv(1, 1, 0, 8'h00, 0, 1, 1, 8'h7E, 1, 1, 0, 0, 8'h7E);
        vecs[22] = mkv(1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 1, 0, 8'h7E);
        vecs[23] = mkv(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h7E);

        for (int i = 0; i < 24; i++) begin
            clr_bar  = vecs[i].clr_bar;
            load_req = vecs[i].load_req;
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            tick();
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
            check($sformatf("v%0d_cpu_hold", i), cpu_hold, vecs[i].hold);
            check($sformatf("v%0d_bus_oe", i),   bus_oe,   vecs[i].oe);
            check($sformatf("v%0d_bus_data", i), bus_data, vecs[i].bd);
            check($sformatf("v%0d_mi_bar", i),   mi_bar,   vecs[i].mi);
            check($sformatf("v%0d_ri", i),       ri,       vecs[i].ri);
            check($sformatf("v%0d_done", i),     done,     vecs[i].done);
            check($sformatf("v%0d_err", i),      err,      vecs[i].err);
            check($sformatf("v%0d_chk", i),      chk,      vecs[i].chk);
        end
        load_req = 1'b0; in_valid = 1'b0;

        // Length 0 means a full 16-word load, with random source gaps.
        stream = {8'h00};
        for (int i = 0; i < 16; i++) stream.push_back(8'(i * 37 + 5));
        do_load("len0_gaps", stream, 1'b1, 0);

        // Length 16 is the largest explicit length.
        stream = {8'h10};
        for (int i = 0; i < 16; i++) stream.push_back(8'(8'hF0 ^ i));
        do_load("len16", stream, 1'b0, 0);

        // Reset during the write-data cycle of byte 2 aborts the load at once.
        stream = {8'h03, 8'h11, 8'h22, 8'h33};
        do_load("abort", stream, 1'b0, 2);
        clr_bar = 1'b0;
        tick();
        clr_bar = 1'b1;
        check("abort_ri", ri, 0);
        check("abort_bus_oe", bus_oe, 0);
        check("abort_cpu_hold", cpu_hold, 0);
        check("abort_mi_bar", mi_bar, 1);
        check("abort_in_ready", in_ready, 0);
        check("abort_chk", chk, 0);

        stream = {8'h02, 8'hC3, 8'h3C};
        do_load("after_abort", stream, 1'b1, 0);
        check("after_abort_chk_ff", chk, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
